// File: rtl/branch_unit_pkg.sv
// Shared definitions for the WISC branch unit: condition codes, flag bit
// positions and the branch FSM state type.
package branch_pkg;

  localparam logic [2:0] COND_NE     = 3'b000;
  localparam logic [2:0] COND_EQ     = 3'b001;
  localparam logic [2:0] COND_GT     = 3'b010;
  localparam logic [2:0] COND_LT     = 3'b011;
  localparam logic [2:0] COND_GTE    = 3'b100;
  localparam logic [2:0] COND_LTE    = 3'b101;
  localparam logic [2:0] COND_OV     = 3'b110;
  localparam logic [2:0] COND_UNCOND = 3'b111;

  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_FLUSH
  } br_state_e;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational condition-code check of a 3-bit code against {N,Z,V}.
module branch_cond_eval
  import branch_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [2:0] flags,
  output logic       taken
);

  logic n, z, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign v = flags[FLAG_V];

  always_comb begin
    taken = 1'b0;
    unique case (cond)
      COND_NE:     taken = ~z;
      COND_EQ:     taken = z;
      COND_GT:     taken = ~z & ~n;
      COND_LT:     taken = n;
      COND_GTE:    taken = z | (~z & ~n);
      COND_LTE:    taken = n | z;
      COND_OV:     taken = v;
      COND_UNCOND: taken = 1'b1;
      default:     taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_unit.sv
// Branch resolution: waits for pending flags, evaluates the condition, and
// issues a one-cycle redirect followed by a FLUSH_CYCLES-long front-end flush.
module branch_unit
  import branch_pkg::*;
#(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned OFF_W        = 9,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              br_valid,
  input  logic              br_is_reg,
  input  logic [2:0]        br_cond,
  input  logic [OFF_W-1:0]  br_offset,
  input  logic [ADDR_W-1:0] pc_plus1,
  input  logic [ADDR_W-1:0] reg_target,
  input  logic [2:0]        flags_in,
  input  logic              flags_pending,
  output logic              hold_req,
  output logic              redirect,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              flush,
  output logic [15:0]       taken_cnt
);

  localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  br_state_e         state, state_nxt;
  logic [2:0]        cond_q;
  logic [ADDR_W-1:0] target_q;
  logic [CNT_W-1:0]  flush_cnt;
  logic [ADDR_W-1:0] target_now;
  logic [2:0]        eval_cond;
  logic [ADDR_W-1:0] eval_target;
  logic              cond_true;
  logic              evaluate;
  logic              taken;

  assign target_now  = br_is_reg ? reg_target
                                 : pc_plus1 + ADDR_W'(signed'(br_offset));

  // In WAIT the condition and target come from the latched copy; the flags are live.
  assign eval_cond   = (state == ST_WAIT) ? cond_q   : br_cond;
  assign eval_target = (state == ST_WAIT) ? target_q : target_now;

  branch_cond_eval u_cond_eval (
    .cond  (eval_cond),
    .flags (flags_in),
    .taken (cond_true)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    evaluate  = 1'b0;
    hold_req  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (br_valid) begin
          if (flags_pending) begin
            hold_req  = 1'b1;
            state_nxt = ST_WAIT;
          end else begin
            evaluate = 1'b1;
            if (cond_true) state_nxt = ST_FLUSH;
          end
        end
      end
      ST_WAIT: begin
        hold_req = 1'b1;
        if (!flags_pending) begin
          evaluate  = 1'b1;
          state_nxt = cond_true ? ST_FLUSH : ST_IDLE;
        end
      end
      ST_FLUSH: begin
        hold_req = 1'b1;
        if (flush_cnt == '0) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign taken = evaluate & cond_true;
  assign flush = (state == ST_FLUSH);

  always_ff @(posedge clk) begin
    if (rst) begin
      redirect    <= 1'b0;
      redirect_pc <= '0;
      cond_q      <= '0;
      target_q    <= '0;
      flush_cnt   <= '0;
      taken_cnt   <= '0;
    end else begin
      redirect <= taken;
      if (taken) redirect_pc <= eval_target;
      if (state == ST_IDLE && br_valid && flags_pending) begin
        cond_q   <= br_cond;
        target_q <= target_now;
      end
      if (taken)
        flush_cnt <= CNT_W'(FLUSH_CYCLES - 1);
      else if (state == ST_FLUSH && flush_cnt != '0)
        flush_cnt <= flush_cnt - 1'b1;
      if (taken && taken_cnt != '1) taken_cnt <= taken_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_branch_unit.sv
// Directed, table-driven bench for branch_unit with hand-computed expectations.
module tb_branch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        br_valid;
  logic        br_is_reg;
  logic [2:0]  br_cond;
  logic [8:0]  br_offset;
  logic [15:0] pc_plus1;
  logic [15:0] reg_target;
  logic [2:0]  flags_in;
  logic        flags_pending;
  logic        hold_req;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        flush;
  logic [15:0] taken_cnt;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [15:0] exp_cnt = '0;
  logic [15:0] exp_rpc = '0;

  typedef struct packed {
    logic [2:0]  cond;
    logic [2:0]  flags;
    logic        is_reg;
    logic [8:0]  off;
    logic [15:0] pc;
    logic [15:0] rt;
    logic        tk;
    logic [15:0] tgt;
  } vec_t;

  vec_t       vecs [8];
  logic [7:0] masks [8];

  branch_unit #(.ADDR_W(16), .OFF_W(9), .FLUSH_CYCLES(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .br_valid      (br_valid),
    .br_is_reg     (br_is_reg),
    .br_cond       (br_cond),
    .br_offset     (br_offset),
    .pc_plus1      (pc_plus1),
    .reg_target    (reg_target),
    .flags_in      (flags_in),
    .flags_pending (flags_pending),
    .hold_req      (hold_req),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .flush         (flush),
    .taken_cnt     (taken_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic run_branch(input string tag, input logic [2:0] c, input logic [2:0] f,
                            input logic r, input logic [8:0] o, input logic [15:0] p,
                            input logic [15:0] t, input logic tk, input logic [15:0] tgt);
    br_valid = 1'b1; br_cond = c; flags_in = f; br_is_reg = r;
    br_offset = o; pc_plus1 = p; reg_target = t; flags_pending = 1'b0;
    #1;
    check({tag, "_hold0"}, 32'(hold_req), 32'd0);
    step();
    br_valid = 1'b0; br_cond = ~c; pc_plus1 = ~p; reg_target = ~t;
    if (tk) begin
      exp_rpc = tgt;
      if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    end
    check({tag, "_redirect"}, 32'(redirect), 32'(tk));
    check({tag, "_rpc"}, 32'(redirect_pc), 32'(exp_rpc));
    check({tag, "_flush1"}, 32'(flush), 32'(tk));
    check({tag, "_hold1"}, 32'(hold_req), 32'(tk));
    step();
    check({tag, "_redirect2"}, 32'(redirect), 32'd0);
    check({tag, "_flush2"}, 32'(flush), 32'(tk));
    step();
    check({tag, "_flush3"}, 32'(flush), 32'd0);
    check({tag, "_cnt"}, 32'(taken_cnt), 32'(exp_cnt));
  endtask

  initial begin
    //            cond    flags   reg  off     pc        rt        tk   tgt
    vecs[0] = '{3'b001, 3'b010, 1'b0, 9'h1FC, 16'h0010, 16'h0000, 1'b1, 16'h000C};
    vecs[1] = '{3'b000, 3'b010, 1'b0, 9'h1FC, 16'h0010, 16'h0000, 1'b0, 16'h0000};
    vecs[2] = '{3'b111, 3'b000, 1'b0, 9'h005, 16'hFFFE, 16'h0000, 1'b1, 16'h0003};
    vecs[3] = '{3'b010, 3'b000, 1'b1, 9'h000, 16'h0000, 16'h4242, 1'b1, 16'h4242};
    vecs[4] = '{3'b110, 3'b110, 1'b0, 9'h010, 16'h0020, 16'h0000, 1'b0, 16'h0000};
    vecs[5] = '{3'b101, 3'b100, 1'b0, 9'h100, 16'h0200, 16'h0000, 1'b1, 16'h0100};
    vecs[6] = '{3'b100, 3'b100, 1'b1, 9'h000, 16'h0000, 16'h7777, 1'b0, 16'h0000};
    vecs[7] = '{3'b111, 3'b101, 1'b0, 9'h0FF, 16'h1000, 16'h0000, 1'b1, 16'h10FF};
    // Truth table per code, indexed by {N,Z,V}.
    masks = '{8'h33, 8'hCC, 8'h03, 8'hF0, 8'hCF, 8'hFC, 8'hAA, 8'hFF};

    rst = 1'b1; br_valid = 1'b0; br_is_reg = 1'b0; br_cond = '0; br_offset = '0;
    pc_plus1 = '0; reg_target = '0; flags_in = '0; flags_pending = 1'b0;
    step(); step();
    check("rst_hold", 32'(hold_req), 32'd0);
    check("rst_redirect", 32'(redirect), 32'd0);
    check("rst_rpc", 32'(redirect_pc), 32'd0);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_cnt", 32'(taken_cnt), 32'd0);
    rst = 1'b0;
    step();

    for (int unsigned i = 0; i < 8; i++) begin
      run_branch($sformatf("vec%0d", i), vecs[i].cond, vecs[i].flags, vecs[i].is_reg,
                 vecs[i].off, vecs[i].pc, vecs[i].rt, vecs[i].tk, vecs[i].tgt);
    end

    for (int unsigned c = 0; c < 8; c++) begin
      for (int unsigned f = 0; f < 8; f++) begin
        logic [7:0]  m;
        logic [15:0] rt;
        m  = masks[c];
        rt = 16'hA000 | 16'(c << 4) | 16'(f);
        run_branch($sformatf("sweep_c%0d_f%0d", c, f), 3'(c), 3'(f), 1'b1, 9'h000,
                   16'h0000, rt, m[f], rt);
      end
    end

    // Pending flags: branch waits three cycles, then resolves on the new flags.
    br_valid = 1'b1; br_cond = 3'b011; br_is_reg = 1'b1; reg_target = 16'hBEEF;
    flags_in = 3'b010; flags_pending = 1'b1;
    #1;
    check("wait_hold_idle", 32'(hold_req), 32'd1);
    step();
    br_valid = 1'b0; br_cond = 3'b000; reg_target = 16'h1234;
    #1;
    check("wait_hold_c1", 32'(hold_req), 32'd1);
    check("wait_redirect_c1", 32'(redirect), 32'd0);
    step();
    check("wait_hold_c2", 32'(hold_req), 32'd1);
    check("wait_flush_c2", 32'(flush), 32'd0);
    flags_pending = 1'b0; flags_in = 3'b100;
    step();
    exp_rpc = 16'hBEEF; exp_cnt = exp_cnt + 16'd1;
    check("wait_redirect", 32'(redirect), 32'd1);
    check("wait_rpc", 32'(redirect_pc), 32'hBEEF);
    check("wait_flush", 32'(flush), 32'd1);
    check("wait_hold_flush", 32'(hold_req), 32'd1);
    step();
    check("wait_redirect_off", 32'(redirect), 32'd0);
    check("wait_flush2", 32'(flush), 32'd1);
    step();
    check("wait_flush_end", 32'(flush), 32'd0);
    check("wait_hold_end", 32'(hold_req), 32'd0);
    check("wait_cnt", 32'(taken_cnt), 32'(exp_cnt));

    // Reset during the first FLUSH cycle drops the branch and clears state.
    br_valid = 1'b1; br_cond = 3'b111; br_is_reg = 1'b0; br_offset = 9'h000;
    pc_plus1 = 16'h0100; flags_pending = 1'b0;
    step();
    br_valid = 1'b0;
    check("rflush_flush", 32'(flush), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    exp_cnt = '0; exp_rpc = '0;
    check("rflush_flush_off", 32'(flush), 32'd0);
    check("rflush_redirect", 32'(redirect), 32'd0);
    check("rflush_rpc", 32'(redirect_pc), 32'd0);
    check("rflush_cnt", 32'(taken_cnt), 32'd0);
    check("rflush_hold", 32'(hold_req), 32'd0);
    run_branch("after_rst", 3'b111, 3'b000, 1'b0, 9'h002, 16'h0300, 16'h0000, 1'b1, 16'h0302);

    // Saturation of the taken counter from a preloaded value.
    force dut.taken_cnt = 16'hFFFD;
    #1;
    release dut.taken_cnt;
    exp_cnt = 16'hFFFD;
    run_branch("sat0", 3'b111, 3'b000, 1'b1, 9'h000, 16'h0000, 16'h0AA0, 1'b1, 16'h0AA0);
    run_branch("sat1", 3'b111, 3'b000, 1'b1, 9'h000, 16'h0000, 16'h0AA1, 1'b1, 16'h0AA1);
    run_branch("sat2", 3'b111, 3'b000, 1'b1, 9'h000, 16'h0000, 16'h0AA2, 1'b1, 16'h0AA2);
    run_branch("sat3", 3'b001, 3'b000, 1'b1, 9'h000, 16'h0000, 16'h0AA3, 1'b0, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
